serial_unadd: RTL and testbench
===============================

Name: serial_unadd

Overview:
- Bit-serial inverse of the 4-bit ripple adder used across the arithmetic labs: given an adder result ({cout,sum}), operand b and carry-in cin, recovers operand a = {cout,sum} - b - cin.
- Processes one bit per clock, LSB first, behind a start/busy/done handshake.
- Used as an in-design checker on adder outputs and as the sequential counterpart in the blocking/non-blocking exercises.

Parameters:
- WIDTH, 4, operand width; minuend is WIDTH+1 bits ({cout,sum}).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- sum  input  WIDTH  adder sum; latched on accepted start
- cout  input  1  adder carry-out; latched on accepted start
- b  input  WIDTH  adder operand b; latched on accepted start
- cin  input  1  adder carry-in; latched on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when a is valid
- a  output  WIDTH  recovered operand; held until next accepted start
- err  output  1  result not representable in WIDTH bits; valid with done, held with a

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, a=0, err=0, bit counter=0, internal borrow=0, operand shift registers=0.
- States:
  - IDLE: start=1 latches {cout,sum} into a (WIDTH+1)-bit minuend shift register and b (zero-extended to WIDTH+1) into the subtrahend register; sets borrow=cin, counter=0, clears the result shift register; next state is SHIFT.
  - SHIFT: busy=1. Each cycle:
    - d = m[0] ^ s[0] ^ borrow
    - borrow_next = (~m[0] & s[0]) | (~m[0] & borrow) | (s[0] & borrow)
    - d shifts into the result MSB; m and s shift right; counter increments.
    - After WIDTH+1 SHIFT cycles (counter == WIDTH), next state is DONE.
  - DONE: a = result[WIDTH-1:0]; err = final borrow OR result[WIDTH]; done=1 for exactly this cycle; busy=0; next state is IDLE.
- Latency: start sampled at edge 0; busy high for edges 1..WIDTH+1; done high during the cycle after edge WIDTH+2 (edge 6 for WIDTH=4). A new start is accepted on the cycle following done at the earliest.
- Boundary conditions:
  - start while busy or in DONE: ignored; inputs are not re-latched.
  - Input changes after an accepted start: no effect on the computation in flight.
  - a and err change only on DONE entry; between operations they hold their last values.
  - rst asserted mid-SHIFT: immediate return to reset values; a partial result is never exposed.
  - start held high continuously: back-to-back operations, one every WIDTH+3 cycles.
- Arithmetic: all internal paths are WIDTH+1 bits. Negative results (final borrow=1) and results at or above 2^WIDTH set err; a then carries the low WIDTH bits of the two's-complement difference.

Optional Feature:
- Macro UNADD_ERR_CHECK_EN.
- Defined: err is computed as described above.
- Undefined: err is tied to 0, result[WIDTH] and the final borrow are discarded, and a is still the low WIDTH bits of the difference. Latency is unchanged.

Test Plan:
- sum=10, cout=1, b=12, cin=0, start pulse: done at edge 6, a=14, err=0, busy high for edges 1..5.
- sum=7, cout=1, b=13, cin=0: a=10, err=0.
- sum=0, cout=1, b=15, cin=1: a=0, err=0 (carry-in subtracted correctly).
- sum=2, cout=0, b=5, cin=0: a=13 (low bits of -3), err=1 with the macro defined, err=0 without it.
- start re-pulsed at edge 3 with sum=0, b=0 during an operation on sum=10, cout=1, b=12: ignored; a=14 at edge 6.
- rst pulsed at edge 3 mid-operation: busy=0, done never fires, a=0; a fresh start afterwards completes normally with full WIDTH+2 latency.

Source files
------------

// File: rtl/serial_unadd.sv
// serial_unadd: bit-serial recovery of adder operand a = {cout,sum} - b - cin, LSB first.
// Optional macro UNADD_ERR_CHECK_EN enables the err (not representable) flag; otherwise err is 0.
`default_nettype none

module serial_unadd #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] sum,
   input  logic             cout,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] a,
   output logic             err
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH:0]     m_q;
   logic [WIDTH:0]     s_q;
   logic [WIDTH:0]     r_q;
   logic               borrow_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   a_q;
   logic               bit_d;
   logic               borrow_d;
`ifdef UNADD_ERR_CHECK_EN
   logic               err_q;
`endif

   // One full-subtractor slice per cycle.
   always_comb begin
      bit_d    = m_q[0] ^ s_q[0] ^ borrow_q;
      borrow_d = (~m_q[0] & s_q[0]) | (~m_q[0] & borrow_q) | (s_q[0] & borrow_q);
   end

   // Outputs are registered from the current state, so busy/done lag the state by one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         m_q      <= '0;
         s_q      <= '0;
         r_q      <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         a_q      <= '0;
`ifdef UNADD_ERR_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         busy_q <= (state_q == S_SHIFT);
         done_q <= (state_q == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  m_q      <= {cout, sum};
                  s_q      <= {1'b0, b};
                  borrow_q <= cin;
                  cnt_q    <= '0;
                  r_q      <= '0;
                  state_q  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_q      <= {bit_d, r_q[WIDTH:1]};
               m_q      <= m_q >> 1;
               s_q      <= s_q >> 1;
               borrow_q <= borrow_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH)) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               a_q     <= r_q[WIDTH-1:0];
`ifdef UNADD_ERR_CHECK_EN
               err_q   <= borrow_q | r_q[WIDTH];
`endif
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign a    = a_q;
`ifdef UNADD_ERR_CHECK_EN
   assign err  = err_q;
`else
   assign err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_unadd.sv
// tb_serial_unadd: directed and random operations on serial_unadd against an arithmetic model.
`default_nettype none

module tb_serial_unadd;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] sum;
   logic         cout;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] a;
   logic         err;

   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] exp_a;
   logic         exp_err;

   serial_unadd #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sum   (sum),
      .cout  (cout),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .a     (a),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // a is the low W bits of the true difference; err flags anything outside 0..2^W-1.
   function automatic void model(input logic [W-1:0] s_in, input logic co,
                                 input logic [W-1:0] b_in, input logic ci,
                                 output logic [W-1:0] ea, output logic ee);
      int diff;
      diff = (co ? (1 << W) : 0) + int'(s_in) - int'(b_in) - (ci ? 1 : 0);
      ea   = W'(diff);
`ifdef UNADD_ERR_CHECK_EN
      ee   = (diff < 0) || (diff >= (1 << W));
`else
      ee   = 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] s_in, input logic co,
                         input logic [W-1:0] b_in, input logic ci,
                         input int repulse_k, input bit keep);
      logic [W-1:0] na;
      logic         ne;
      model(s_in, co, b_in, ci, na, ne);
      sum = s_in; cout = co; b = b_in; cin = ci; start = 1'b1;
      tick();
      if (!keep) start = 1'b0;
      sum  = W'($urandom);
      b    = W'($urandom);
      cout = 1'($urandom);
      cin  = 1'($urandom);
      for (int k = 1; k <= W + 2; k++) begin
         if (k == repulse_k) begin
            start = 1'b1; sum = '0; b = '0; cout = 1'b0; cin = 1'b0;
         end
         tick();
         if (k == repulse_k && !keep) start = 1'b0;
         chk($sformatf("%s busy k%0d", tag, k), 32'(busy), 32'(k <= W + 1));
         chk($sformatf("%s done k%0d", tag, k), 32'(done), 32'(k == W + 2));
         if (k <= W + 1) begin
            chk($sformatf("%s a_hold k%0d", tag, k), 32'(a), 32'(exp_a));
            chk($sformatf("%s err_hold k%0d", tag, k), 32'(err), 32'(exp_err));
         end else begin
            chk($sformatf("%s a", tag), 32'(a), 32'(na));
            chk($sformatf("%s err", tag), 32'(err), 32'(ne));
         end
      end
      exp_a   = na;
      exp_err = ne;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; sum = '0; cout = 1'b0; b = '0; cin = 1'b0;
      exp_a = '0; exp_err = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("reset busy", 32'(busy), 32'(0));
      chk("reset done", 32'(done), 32'(0));
      chk("reset a", 32'(a), 32'(0));
      chk("reset err", 32'(err), 32'(0));
      tick();
      tick();
      rst = 1'b0;
      tick();

      run_op("plan1", 4'd10, 1'b1, 4'd12, 1'b0, 0, 1'b0);
      run_op("plan2", 4'd7,  1'b1, 4'd13, 1'b0, 0, 1'b0);
      run_op("plan3", 4'd0,  1'b1, 4'd15, 1'b1, 0, 1'b0);
      run_op("plan4", 4'd2,  1'b0, 4'd5,  1'b0, 0, 1'b0);
      run_op("repulse", 4'd10, 1'b1, 4'd12, 1'b0, 3, 1'b0);
      tick();

      for (int i = 0; i < 20; i++) begin
         run_op($sformatf("rand%0d", i), W'($urandom), 1'($urandom), W'($urandom),
                1'($urandom), 0, 1'b0);
         if (($urandom % 2) == 0) tick();
      end

      for (int i = 0; i < 4; i++) begin
         run_op($sformatf("b2b%0d", i), W'($urandom), 1'($urandom), W'($urandom),
                1'($urandom), 0, 1'b1);
      end
      start = 1'b0;
      tick();

      // Asynchronous reset in the middle of an operation.
      sum = 4'd10; cout = 1'b1; b = 4'd12; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      exp_a = '0; exp_err = 1'b0;
      chk("midrst busy", 32'(busy), 32'(0));
      chk("midrst done", 32'(done), 32'(0));
      chk("midrst a", 32'(a), 32'(0));
      chk("midrst err", 32'(err), 32'(0));
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("postrst done k%0d", k), 32'(done), 32'(0));
         chk($sformatf("postrst busy k%0d", k), 32'(busy), 32'(0));
         chk($sformatf("postrst a k%0d", k), 32'(a), 32'(0));
      end
      run_op("fresh", 4'd7, 1'b1, 4'd13, 1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
